mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. It consumes the EXE/MEM pipeline register outputs and performs loads and stores on an external data memory over a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and registers the MEM/WB values for the writeback stage.

Parameters:
WORD_LEN, 32, data/address width
REG_ADDR_LEN, 5, register-file destination index width
INST_LEN, 32, PC width
ACK_TIMEOUT, 16, max cycles in ACCESS before abort (>=1)

Ports:
i_sys_clk  in  1  system clock, rising edge
i_sys_rst  in  1  asynchronous, active-high reset
i_writeback_en_in  in  1  instruction writes the register file
i_dest_in  in  REG_ADDR_LEN  destination register
i_PC_in  in  INST_LEN  instruction PC
i_ALU_result_in  in  WORD_LEN  ALU result / memory address
i_STvalue_in  in  WORD_LEN  store data
i_MEM_Rd_en  in  1  load
i_MEM_Wr_en  in  1  store
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1=write, 0=read
o_dmem_addr  out  WORD_LEN  memory byte address
o_dmem_wdata  out  WORD_LEN  store data
i_dmem_ack  in  1  memory completes the request this cycle
i_dmem_rdata  in  WORD_LEN  read data, valid with ack
o_stall  out  1  upstream registers and PC hold while high
o_writeback_en_out  out  1  MEM/WB writeback enable
o_dest_out  out  REG_ADDR_LEN  MEM/WB destination
o_PC_out  out  INST_LEN  MEM/WB PC
o_wb_data_out  out  WORD_LEN  load data or ALU result
o_MEM_Rd_en_out  out  1  MEM/WB was a load
o_bus_err  out  1  sticky: timeout or misaligned access

Behaviour:
- Reset (async, i_sys_rst=1): state IDLE, timeout counter 0, all outputs 0 immediately. This includes o_dmem_req, so an in-flight access is abandoned. Any late ack after reset is ignored.
- States: IDLE, ACCESS.
- IDLE, no memory op (Rd=Wr=0): on the next edge, the MEM/WB register loads writeback_en, dest, PC, wb_data=ALU_result and MEM_Rd_en_out=0. Latency 1 cycle. o_stall=0.
- IDLE with a memory op: o_stall=1 combinationally.
  - Both Rd and Wr high: treated as a store.
  - If ALU_result[1:0]!=0 (misaligned): no request, o_bus_err set. MEM/WB loads a bubble (writeback_en=0, other fields from inputs) and o_stall=0 in that cycle.
  - Otherwise, on the next edge: enter ACCESS, o_dmem_req=1, latch o_dmem_we, addr=ALU_result, wdata=STvalue, plus dest, PC, writeback_en and Rd. MEM/WB loads a bubble (writeback_en=0).
- ACCESS: req, we, addr and wdata are held stable until ack. o_stall = ~i_dmem_ack.
  - On ack: next edge returns to IDLE with req=0. MEM/WB loads the latched fields; wb_data = i_dmem_rdata for a load, latched ALU result for a store. writeback_en is the latched value, forced 0 for a store. Upstream advances on the same edge.
  - Minimum load/store latency: 2 cycles (request issued edge 1, ack in cycle 1, result at edge 2).
- Timeout counter: cleared on entering ACCESS, increments each ACCESS cycle without ack. When the count reaches ACK_TIMEOUT with no ack:
  - drop req, set o_bus_err, load a bubble into MEM/WB, return to IDLE, o_stall=0 that cycle.
  - An ack in the same cycle as the timeout wins (normal completion).
- i_dmem_ack while IDLE: ignored.
- o_bus_err clears only on reset.
- While o_stall=1, the stage's own inputs are assumed held by upstream. The stage uses only the values latched on the IDLE->ACCESS edge.

Test Plan:
- Reset, then an ALU op (writeback_en=1, dest=5, ALU_result=0x1234, Rd=Wr=0) -> next edge o_writeback_en_out=1, o_dest_out=5, o_wb_data_out=0x1234, o_stall never 1.
- Load addr 0x100, ack after 3 ACCESS cycles with rdata 0xDEADBEEF:
  - o_stall high for 4 cycles
  - o_dmem_addr=0x100 and o_dmem_we=0 stable throughout
  - then o_wb_data_out=0xDEADBEEF, o_MEM_Rd_en_out=1, o_writeback_en_out=1
- Store addr 0x200, STvalue 0xA5A5A5A5, immediate ack -> o_dmem_we=1, o_dmem_wdata=0xA5A5A5A5, one request cycle, o_writeback_en_out=0.
- Load addr 0x102 -> no o_dmem_req, o_bus_err=1, bubble written, o_stall=0 after that cycle.
- Load with no ack (ACK_TIMEOUT=16) -> req held exactly 16 cycles, then dropped, o_bus_err=1, bubble in MEM/WB. A second test with ack in cycle 16 -> normal completion, o_bus_err=0.
- Assert i_sys_rst mid-ACCESS -> o_dmem_req and o_stall drop before the next clock edge. A subsequent stray ack produces no MEM/WB update.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage MIPS pipeline. It takes the EXE/MEM register
// outputs, performs loads and stores on an external data memory over a
// req/ack handshake, stalls upstream while an access is outstanding, and
// registers the MEM/WB values for the writeback stage.
//
// Ports
//   i_sys_clk, i_sys_rst       clock (rising edge), async active-high reset
//   i_writeback_en_in          instruction writes the register file
//   i_dest_in                  destination register index
//   i_PC_in                    instruction PC
//   i_ALU_result_in            ALU result, also the memory byte address
//   i_STvalue_in               store data
//   i_MEM_Rd_en, i_MEM_Wr_en   load / store request (both high = store)
//   o_dmem_req/we/addr/wdata   data-memory request, held stable until ack
//   i_dmem_ack, i_dmem_rdata   memory completion and read data
//   o_stall                    upstream registers and PC hold while high
//   o_writeback_en_out, o_dest_out, o_PC_out, o_wb_data_out, o_MEM_Rd_en_out
//                              MEM/WB pipeline register
//   o_bus_err                  sticky flag: ack timeout or misaligned access
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int INST_LEN     = 32,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_writeback_en_in,
  input  logic [REG_ADDR_LEN-1:0] i_dest_in,
  input  logic [INST_LEN-1:0]     i_PC_in,
  input  logic [WORD_LEN-1:0]     i_ALU_result_in,
  input  logic [WORD_LEN-1:0]     i_STvalue_in,
  input  logic                    i_MEM_Rd_en,
  input  logic                    i_MEM_Wr_en,
  output logic                    o_dmem_req,
  output logic                    o_dmem_we,
  output logic [WORD_LEN-1:0]     o_dmem_addr,
  output logic [WORD_LEN-1:0]     o_dmem_wdata,
  input  logic                    i_dmem_ack,
  input  logic [WORD_LEN-1:0]     i_dmem_rdata,
  output logic                    o_stall,
  output logic                    o_writeback_en_out,
  output logic [REG_ADDR_LEN-1:0] o_dest_out,
  output logic [INST_LEN-1:0]     o_PC_out,
  output logic [WORD_LEN-1:0]     o_wb_data_out,
  output logic                    o_MEM_Rd_en_out,
  output logic                    o_bus_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;

  // Fields captured on the IDLE->ACCESS edge; upstream is stalled, so these
  // are the only copies of the instruction the stage relies on afterwards.
  logic                    wb_en_p1;
  logic [REG_ADDR_LEN-1:0] dest_p1;
  logic [INST_LEN-1:0]     pc_p1;
  logic                    load_p1;
  logic [CNT_W-1:0]        tmo_cnt;

  logic mem_op;
  logic misaligned;
  logic timeout_hit;

  assign mem_op     = i_MEM_Rd_en | i_MEM_Wr_en;
  assign misaligned = (i_ALU_result_in[1:0] != 2'b00);

  // The counter holds the number of ack-less ACCESS cycles already seen, so
  // the current cycle is the last allowed one when it equals ACK_TIMEOUT-1.
  // An ack arriving in that same cycle takes priority.
  assign timeout_hit = (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1)) & ~i_dmem_ack;

  // Stall is gated by reset so it drops immediately when reset asserts,
  // even if upstream is still presenting a memory op.
  always_comb begin
    o_stall = 1'b0;
    if (!i_sys_rst) begin
      case (state)
        IDLE:    o_stall = mem_op & ~misaligned;
        ACCESS:  o_stall = ~i_dmem_ack & ~timeout_hit;
        default: o_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state              <= IDLE;
      tmo_cnt            <= '0;
      o_dmem_req         <= 1'b0;
      o_dmem_we          <= 1'b0;
      o_dmem_addr        <= '0;
      o_dmem_wdata       <= '0;
      wb_en_p1           <= 1'b0;
      dest_p1            <= '0;
      pc_p1              <= '0;
      load_p1            <= 1'b0;
      o_writeback_en_out <= 1'b0;
      o_dest_out         <= '0;
      o_PC_out           <= '0;
      o_wb_data_out      <= '0;
      o_MEM_Rd_en_out    <= 1'b0;
      o_bus_err          <= 1'b0;
    end else begin
      case (state)
        // ---- IDLE: pass-through, reject misaligned, or launch a request ----
        IDLE: begin
          o_dest_out      <= i_dest_in;
          o_PC_out        <= i_PC_in;
          o_wb_data_out   <= i_ALU_result_in;
          o_MEM_Rd_en_out <= 1'b0;
          if (!mem_op) begin
            o_writeback_en_out <= i_writeback_en_in;
          end else if (misaligned) begin
            o_writeback_en_out <= 1'b0;
            o_bus_err          <= 1'b1;
          end else begin
            o_writeback_en_out <= 1'b0;
            state              <= ACCESS;
            tmo_cnt            <= '0;
            o_dmem_req         <= 1'b1;
            o_dmem_we          <= i_MEM_Wr_en;
            o_dmem_addr        <= i_ALU_result_in;
            o_dmem_wdata       <= i_STvalue_in;
            wb_en_p1           <= i_writeback_en_in;
            dest_p1            <= i_dest_in;
            pc_p1              <= i_PC_in;
            load_p1            <= i_MEM_Rd_en & ~i_MEM_Wr_en;
          end
        end

        // ---- ACCESS: hold the request until ack or timeout ----
        ACCESS: begin
          if (i_dmem_ack) begin
            state              <= IDLE;
            o_dmem_req         <= 1'b0;
            o_writeback_en_out <= wb_en_p1 & load_p1;
            o_dest_out         <= dest_p1;
            o_PC_out           <= pc_p1;
            o_wb_data_out      <= load_p1 ? i_dmem_rdata : o_dmem_addr;
            o_MEM_Rd_en_out    <= load_p1;
          end else if (timeout_hit) begin
            state              <= IDLE;
            o_dmem_req         <= 1'b0;
            o_bus_err          <= 1'b1;
            o_writeback_en_out <= 1'b0;
            o_dest_out         <= dest_p1;
            o_PC_out           <= pc_p1;
            o_wb_data_out      <= o_dmem_addr;
            o_MEM_Rd_en_out    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en_in = 1'b0;
  logic [4:0]  dest_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] alu_in = '0;
  logic [31:0] st_in = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall;
  logic        wb_en_out;
  logic [4:0]  dest_out;
  logic [31:0] pc_out;
  logic [31:0] wb_data_out;
  logic        rd_en_out;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  int stall_cycles;

  mem_access_stage #(
    .WORD_LEN(32), .REG_ADDR_LEN(5), .INST_LEN(32), .ACK_TIMEOUT(16)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .i_writeback_en_in(wb_en_in),
    .i_dest_in(dest_in),
    .i_PC_in(pc_in),
    .i_ALU_result_in(alu_in),
    .i_STvalue_in(st_in),
    .i_MEM_Rd_en(rd_en),
    .i_MEM_Wr_en(wr_en),
    .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata),
    .i_dmem_ack(dmem_ack),
    .i_dmem_rdata(dmem_rdata),
    .o_stall(stall),
    .o_writeback_en_out(wb_en_out),
    .o_dest_out(dest_out),
    .o_PC_out(pc_out),
    .o_wb_data_out(wb_data_out),
    .o_MEM_Rd_en_out(rd_en_out),
    .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; all driving/sampling happens 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [4:0] d, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] st,
                        input logic rd, input logic wr);
    wb_en_in = we; dest_in = d; pc_in = pc; alu_in = alu; st_in = st;
    rd_en = rd; wr_en = wr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wb_en", {31'b0, wb_en_out}, 32'd0);
    chk("rst_wb_data", wb_data_out, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);

    // ALU op: one-cycle pass-through
    set_in(1'b1, 5'd5, 32'h10, 32'h1234, 32'h0, 1'b0, 1'b0);
    #1 chk("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("alu_wb_en", {31'b0, wb_en_out}, 32'd1);
    chk("alu_dest", {27'b0, dest_out}, 32'd5);
    chk("alu_wb_data", wb_data_out, 32'h1234);
    chk("alu_pc", pc_out, 32'h10);
    chk("alu_rd_out", {31'b0, rd_en_out}, 32'd0);
    chk("alu_stall2", {31'b0, stall}, 32'd0);

    // Load 0x100, ack in the 4th ACCESS cycle (after 3 without ack)
    set_in(1'b1, 5'd7, 32'h40, 32'h100, 32'h0, 1'b1, 1'b0);
    stall_cycles = 0;
    #1;
    chk("ld_idle_req", {31'b0, dmem_req}, 32'd0);
    if (stall) stall_cycles++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_req", {31'b0, dmem_req}, 32'd1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", {31'b0, dmem_we}, 32'd0);
      chk("ld_bubble", {31'b0, wb_en_out}, 32'd0);
      if (stall) stall_cycles++;
    end
    tick();
    chk("ld_addr_last", dmem_addr, 32'h100);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    if (stall) stall_cycles++;
    chk("ld_stall_cycles", stall_cycles, 32'd4);
    tick();
    dmem_ack = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("ld_wb_data", wb_data_out, 32'hDEADBEEF);
    chk("ld_rd_out", {31'b0, rd_en_out}, 32'd1);
    chk("ld_wb_en", {31'b0, wb_en_out}, 32'd1);
    chk("ld_dest", {27'b0, dest_out}, 32'd7);
    chk("ld_req_drop", {31'b0, dmem_req}, 32'd0);

    // Store 0x200 (Rd and Wr both high => store), immediate ack
    set_in(1'b1, 5'd9, 32'h44, 32'h200, 32'hA5A5A5A5, 1'b1, 1'b1);
    #1 chk("st_idle_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("st_req", {31'b0, dmem_req}, 32'd1);
    chk("st_we", {31'b0, dmem_we}, 32'd1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_addr", dmem_addr, 32'h200);
    dmem_ack = 1'b1;
    #1 chk("st_ack_stall", {31'b0, stall}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("st_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("st_wb_en", {31'b0, wb_en_out}, 32'd0);
    chk("st_wb_data", wb_data_out, 32'h200);
    chk("st_rd_out", {31'b0, rd_en_out}, 32'd0);

    // Load with ack in the 16th ACCESS cycle: normal completion
    set_in(1'b1, 5'd3, 32'h48, 32'h300, 32'h0, 1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 15; k++) begin
      chk("t16_req", {31'b0, dmem_req}, 32'd1);
      chk("t16_stall", {31'b0, stall}, 32'd1);
      tick();
    end
    chk("t16_req_last", {31'b0, dmem_req}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1 chk("t16_ack_stall", {31'b0, stall}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t16_wb_data", wb_data_out, 32'hCAFEF00D);
    chk("t16_wb_en", {31'b0, wb_en_out}, 32'd1);
    chk("t16_bus_err", {31'b0, bus_err}, 32'd0);
    chk("t16_req_drop", {31'b0, dmem_req}, 32'd0);

    // Misaligned load 0x102: no request, bubble, sticky error
    set_in(1'b1, 5'd4, 32'h50, 32'h102, 32'h0, 1'b1, 1'b0);
    #1;
    chk("mis_stall", {31'b0, stall}, 32'd0);
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("mis_req2", {31'b0, dmem_req}, 32'd0);
    chk("mis_bus_err", {31'b0, bus_err}, 32'd1);
    chk("mis_wb_en", {31'b0, wb_en_out}, 32'd0);
    chk("mis_dest", {27'b0, dest_out}, 32'd4);
    tick();
    chk("mis_sticky", {31'b0, bus_err}, 32'd1);
    chk("mis_stall2", {31'b0, stall}, 32'd0);

    // Reset clears the sticky error
    do_reset();
    chk("rst2_bus_err", {31'b0, bus_err}, 32'd0);

    // Load with no ack: request held exactly 16 cycles, then timeout
    set_in(1'b1, 5'd6, 32'h60, 32'h400, 32'h0, 1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 15; k++) begin
      chk("tmo_req", {31'b0, dmem_req}, 32'd1);
      chk("tmo_stall", {31'b0, stall}, 32'd1);
      tick();
    end
    chk("tmo_req16", {31'b0, dmem_req}, 32'd1);
    chk("tmo_stall16", {31'b0, stall}, 32'd0);
    chk("tmo_err_pre", {31'b0, bus_err}, 32'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("tmo_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("tmo_bus_err", {31'b0, bus_err}, 32'd1);
    chk("tmo_wb_en", {31'b0, wb_en_out}, 32'd0);
    chk("tmo_dest", {27'b0, dest_out}, 32'd6);

    // Reset asserted mid-ACCESS, followed by stray acks
    do_reset();
    set_in(1'b1, 5'd8, 32'h70, 32'h500, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    chk("mid_req", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    #1;
    chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("stray_wb_data", wb_data_out, 32'h0);
    chk("stray_wb_en", {31'b0, wb_en_out}, 32'd0);
    chk("stray_rd_out", {31'b0, rd_en_out}, 32'd0);
    chk("stray_req", {31'b0, dmem_req}, 32'd0);
    dmem_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
